// File: rtl/fifo_pkg.sv
// Shared constants for the 2:1 width-converting FIFO: depth helper and
// read-side half-select encoding used by the controller and the read mux.
package fifo_pkg;

  localparam logic SEL_LO = 1'b0;
  localparam logic SEL_HI = 1'b1;

  // Number of full-width word slots for a given address width.
  function automatic int unsigned depth(input int unsigned addr_width);
    return 32'(1) << addr_width;
  endfunction

endpackage

// File: rtl/fifo_ctrl_2to1.sv
// Pointer and status controller for the 2:1 width-converting FIFO.
// Each write stores one double-width word; each read consumes one half,
// lower half first. A word slot is freed only once its upper half is read.
module fifo_ctrl_2to1
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  r_sel,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int unsigned DEPTH = depth(ADDR_WIDTH);
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
  logic                  r_sel_q, r_sel_d;
  logic [CW-1:0]         count_q, count_d;

  logic wr_ok;
  logic rd_ok;
  logic retire;

  // Status flags decode only from the registered occupancy count.
  always_comb begin
    full   = (count_q == CW'(DEPTH));
    empty  = (count_q == '0);
    wr_ok  = wr & ~full;
    rd_ok  = rd & ~empty;
    retire = rd_ok & (r_sel_q == SEL_HI);
  end

  // Next-state: pointer advance, half toggle and occupancy update.
  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    r_sel_d = r_sel_q;
    count_d = count_q;

    if (wr_ok) begin
      w_ptr_d = w_ptr_q + ADDR_WIDTH'(1);
    end

    if (rd_ok) begin
      if (r_sel_q == SEL_LO) begin
        r_sel_d = SEL_HI;
      end else begin
        r_sel_d = SEL_LO;
        r_ptr_d = r_ptr_q + ADDR_WIDTH'(1);
      end
    end

    unique case ({wr_ok, retire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset also discards any half-read word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      r_sel_q <= SEL_LO;
      count_q <= '0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      r_sel_q <= r_sel_d;
      count_q <= count_d;
    end
  end

  // Storage-side outputs; w_en must be combinational so storage captures
  // w_data on the same edge that advances the write pointer.
  always_comb begin
    w_en   = wr_ok;
    w_addr = w_ptr_q;
    r_addr = r_ptr_q;
    r_sel  = r_sel_q;
    count  = count_q;
  end

endmodule

// File: tb/tb_fifo_ctrl_2to1.sv
// Scoreboard bench for fifo_ctrl_2to1 with a behavioural storage array and
// half mux around the controller, as the parent fifo_2to1 would build them.
module tb_fifo_ctrl_2to1;
  import fifo_pkg::*;

  localparam int unsigned AW = 2;

  logic          clk;
  logic          reset_n;
  logic          wr;
  logic          rd;
  logic          w_en;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] r_addr;
  logic          r_sel;
  logic          full;
  logic          empty;
  logic [AW:0]   count;

  logic [15:0]   w_data;
  logic [15:0]   mem [4];
  logic [7:0]    r_half;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  fifo_ctrl_2to1 #(.ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wr      (wr),
    .rd      (rd),
    .w_en    (w_en),
    .w_addr  (w_addr),
    .r_addr  (r_addr),
    .r_sel   (r_sel),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Storage array and read-side half mux.
  always @(posedge clk) if (w_en) mem[w_addr] <= w_data;
  always_comb r_half = (r_sel == SEL_HI) ? mem[r_addr][15:8] : mem[r_addr][7:0];

  function automatic void chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every rd cycle either consumes the next expected half or must see empty.
  always @(negedge clk) begin
    if (reset_n && rd) begin
      if (exp_q.size() == 0) begin
        chk("rd_while_empty", 32'(empty), 1);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("empty_on_read", 32'(empty), 0);
        chk("read_half", 32'(r_half), 32'(e));
      end
    end
  end

  // One clock of stimulus; exp_acc is the hand-derived write acceptance.
  task automatic cyc(input logic w, input logic r, input logic [15:0] d, input logic exp_acc);
    wr = w; rd = r; w_data = d;
    @(negedge clk);
    chk("w_en", 32'(w_en), 32'(w & exp_acc));
    @(posedge clk);
    if (w && exp_acc) begin
      exp_q.push_back(d[7:0]);
      exp_q.push_back(d[15:8]);
    end
    #1;
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic check_state(input string tag, input int unsigned e_waddr, input int unsigned e_raddr,
                             input int unsigned e_sel, input int unsigned e_cnt,
                             input int unsigned e_full, input int unsigned e_empty);
    @(negedge clk);
    chk({tag, "_w_addr"}, 32'(w_addr), e_waddr);
    chk({tag, "_r_addr"}, 32'(r_addr), e_raddr);
    chk({tag, "_r_sel"},  32'(r_sel),  e_sel);
    chk({tag, "_count"},  32'(count),  e_cnt);
    chk({tag, "_full"},   32'(full),   e_full);
    chk({tag, "_empty"},  32'(empty),  e_empty);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; wr = 1'b0; rd = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; wr = 1'b1; rd = 1'b1; w_data = 16'h0;

    // Reset held with requests active, then idle.
    repeat (3) @(posedge clk);
    #1; wr = 1'b0; rd = 1'b0; reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset_idle", 0, 0, 0, 0, 0, 1);

    // Single word, three consecutive reads; the third is ignored.
    cyc(1'b1, 1'b0, 16'hBEEF, 1'b1);
    cyc(1'b0, 1'b1, 16'h0, 1'b0);
    cyc(1'b0, 1'b1, 16'h0, 1'b0);
    cyc(1'b0, 1'b1, 16'h0, 1'b0);
    check_state("single", 1, 1, 0, 0, 0, 1);

    // Fill to full; fifth write dropped.
    do_reset();
    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, {8'(i), 8'(i)}, (i <= 4));
    check_state("full", 0, 0, 0, 4, 1, 0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 16'h0, 1'b0);
    check_state("drained", 0, 0, 0, 0, 0, 1);

    // Full plus retiring read with simultaneous write: write rejected.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, {8'(8'hA0 + i), 8'(8'h50 + i)}, 1'b1);
    cyc(1'b0, 1'b1, 16'h0, 1'b0);
    cyc(1'b1, 1'b1, 16'hDEAD, 1'b0);
    check_state("full_rd", 0, 1, 0, 3, 0, 0);
    cyc(1'b1, 1'b0, 16'hC3C4, 1'b1);
    check_state("after_full", 1, 1, 0, 4, 1, 0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 16'h0, 1'b0);
    check_state("full_drain", 1, 1, 0, 0, 0, 1);

    // Empty with simultaneous write and read: read rejected.
    do_reset();
    cyc(1'b1, 1'b1, 16'h1234, 1'b1);
    check_state("empty_wr", 1, 0, 0, 1, 0, 0);
    cyc(1'b0, 1'b1, 16'h0, 1'b0);
    cyc(1'b0, 1'b1, 16'h0, 1'b0);
    check_state("empty_drain", 1, 1, 0, 0, 0, 1);

    // Streaming across two pointer wraps.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, (i > 0), {8'(8'h80 + i), 8'(8'h10 + i)}, 1'b1);
      cyc(1'b0, (i > 0), 16'h0, 1'b0);
    end
    cyc(1'b0, 1'b1, 16'h0, 1'b0);
    cyc(1'b0, 1'b1, 16'h0, 1'b0);
    check_state("wrap", 2, 2, 0, 0, 0, 1);

    // Asynchronous reset with a half-read word outstanding.
    cyc(1'b1, 1'b0, 16'h7788, 1'b1);
    cyc(1'b0, 1'b1, 16'h0, 1'b0);
    check_state("pre_reset", 3, 2, 1, 1, 0, 0);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_w_addr", 32'(w_addr), 0);
    chk("async_r_addr", 32'(r_addr), 0);
    chk("async_r_sel",  32'(r_sel),  0);
    chk("async_count",  32'(count),  0);
    chk("async_full",   32'(full),   0);
    chk("async_empty",  32'(empty),  1);
    chk("async_w_en",   32'(w_en),   0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    check_state("post_reset", 0, 0, 0, 0, 0, 1);

    chk("queue_leftover", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
